gray_ptr_rx: RTL and testbench
==============================

# gray_ptr_rx

Receive-side counterpart of the FIFO's binary-to-Gray pointer encoder. It takes a Gray-coded pointer launched from the opposite clock domain and passes it through a multi-flop synchronizer. It then decodes the pointer back to binary, reports how far the pointer advanced, and flags any synchronized step that breaks the single-bit-change Gray property. One instance sits in each FIFO domain: write pointer into the read domain, read pointer into the write domain.

## Interface
- WIDTH, 8, pointer width in bits (≥2)
- SYNC_STAGES, 2, synchronizer flop count (≥2)

- clk  in  1  receiving-domain clock
- rst_n  in  1  synchronous, active-low reset
- gray_in  in  WIDTH  Gray pointer from the remote domain (asynchronous to clk; registered at source)
- err_clr  in  1  synchronous clear of err_multi
- gray_sync  out  WIDTH  last synchronizer stage (raw Gray, synchronized)
- bin_out  out  WIDTH  decoded binary pointer, registered
- advance  out  WIDTH  (new bin_out − old bin_out) mod 2^WIDTH, valid when update=1, else 0
- update  out  1  one-cycle pulse: bin_out took a new value this cycle
- err_multi  out  1  sticky: a synchronized step changed more than one Gray bit
- primed  out  1  high once the initial pointer value is loaded (TRACK state)

## Operation
- Synchronizer: s[0] ← gray_in, s[k] ← s[k-1]; gray_sync = s[SYNC_STAGES-1]. There is no logic between the synchronizer flops.
- Decode (combinational, on gray_sync): b[W-1] = g[W-1]; b[i] = b[i+1] ^ g[i].
- State machine, 2 states:
  - PRIME (reset state): a counter counts SYNC_STAGES enabled cycles to flush stale synchronizer contents. On the following edge, bin_out ← decode(gray_sync) and prev_gray ← gray_sync. No update pulse, no error check. The FSM then goes to TRACK and sets primed=1.
  - TRACK, when gray_sync ≠ prev_gray:
    - bin_out ← decode
    - advance ← decode − bin_out (mod 2^WIDTH)
    - update ← 1
    - prev_gray ← gray_sync
    - if popcount(gray_sync ^ prev_gray) > 1, set err_multi.
  - TRACK, when gray_sync = prev_gray: update ← 0, advance ← 0, bin_out held.
- err_multi: set by a violation and cleared by err_clr. When set and clear occur on the same edge, set wins. The flag is never cleared by anything else except reset.
- Wrap-around is natural modulo arithmetic. A Gray step from 2^(W-1) to 0 decodes as 2^W−1 → 0 with advance=1 and no error.
- Reset, including reset asserted mid-operation, sampled at an edge clears every register on that edge:
  - the synchronizer chain
  - bin_out, advance, update, err_multi, primed, prev_gray, the PRIME counter (all to 0)
  - the FSM returns to PRIME.
- The block places no restriction on the remote update rate. If the remote pointer steps faster than clk, multi-step jumps appear as advance>1. Those same jumps also set err_multi, which system integration must treat as a rate violation.

## Timing
- gray_in → gray_sync: SYNC_STAGES cycles.
- gray_in → bin_out/update/advance/err_multi: SYNC_STAGES+1 cycles. All four are registered and change on the same edge.
- After reset release, counting edge 1 as the first edge with rst_n=1:
  - gray_sync holds the sampled pointer at edge SYNC_STAGES.
  - bin_out is loaded and primed=1 at edge SYNC_STAGES+1.
  - The first possible update pulse is at edge SYNC_STAGES+2.
- update is high for exactly one cycle per change. A gray_sync that changes on consecutive cycles produces back-to-back update pulses.
- err_clr takes effect on the next edge. err_multi reads 0 from then on unless a new violation occurs on that same edge.

## Test plan
- WIDTH=8, SYNC_STAGES=2, reset with gray_in=0x00; remote binary count 0→255 applied as Gray, one step every 3 clk → bin_out tracks each value 3 cycles after gray_in changes, advance=1 on every update, err_multi=0.
- Wrap: gray_in 0x80 (bin 0xFF) → 0x00 → bin_out 0xFF→0x00, update=1, advance=0x01, err_multi stays 0.
- Violation: tracking at gray 0x00, gray_in jumps to 0x03 and holds → bin_out=0x02, advance=0x02, err_multi=1 on the same edge and sticky; pulse err_clr one cycle → err_multi=0 next edge.
- Prime: release reset with gray_in=0xC0 held → bin_out=0x80 and primed=1 at edge 3, no update pulse, err_multi=0.
- Mid-operation reset: while tracking at bin_out=0x55, drive rst_n=0 for one cycle → all outputs 0 after that edge; primed returns after SYNC_STAGES+1 enabled cycles with the current pointer value.
- Simultaneous: err_clr=1 on the same edge a 2-bit Gray step is synchronized → err_multi remains 1.

Source files
------------

// File: rtl/gray_ptr_rx.sv
// gray_ptr_rx: synchronize a remote Gray pointer, decode it, report advance and multi-bit steps
module gray_ptr_rx #(
  parameter int WIDTH = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] gray_in,
  input  logic             err_clr,
  output logic [WIDTH-1:0] gray_sync,
  output logic [WIDTH-1:0] bin_out,
  output logic [WIDTH-1:0] advance,
  output logic             update,
  output logic             err_multi,
  output logic             primed
);
  typedef enum logic {PRIME, TRACK} state_t;
  localparam int CW = $clog2(SYNC_STAGES + 1);
  logic [WIDTH-1:0] s [SYNC_STAGES];
  logic [WIDTH-1:0] dec, prev_gray, prev_nx, bin_nx, adv_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic upd_nx, err_nx;
  state_t state, state_nx;
  // plain flop chain, nothing between stages
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) s[k] <= '0;
    end else begin
      s[0] <= gray_in;
      for (int k = 1; k < SYNC_STAGES; k++) s[k] <= s[k-1];
    end
  end
  assign gray_sync = s[SYNC_STAGES-1];
  assign primed = state == TRACK;
  // binary bit i is the xor of all Gray bits at or above i
  always_comb begin
    dec = '0;
    for (int i = 0; i < WIDTH; i++) dec[i] = ^(gray_sync >> i);
  end
  // flush the chain while priming, then track changes of the synchronized pointer
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    bin_nx = bin_out;
    adv_nx = '0;
    upd_nx = 1'b0;
    prev_nx = prev_gray;
    err_nx = err_multi & ~err_clr;
    if (state == PRIME) begin
      if (cnt == CW'(SYNC_STAGES)) begin
        bin_nx = dec;
        prev_nx = gray_sync;
        state_nx = TRACK;
      end else begin
        cnt_nx = cnt + 1'b1;
      end
    end else if (gray_sync != prev_gray) begin
      bin_nx = dec;
      adv_nx = dec - bin_out;
      upd_nx = 1'b1;
      prev_nx = gray_sync;
      err_nx = err_nx | ($countones(gray_sync ^ prev_gray) > 1);
    end
  end
  // state and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= PRIME;
      cnt <= '0;
      bin_out <= '0;
      advance <= '0;
      update <= 1'b0;
      prev_gray <= '0;
      err_multi <= 1'b0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      bin_out <= bin_nx;
      advance <= adv_nx;
      update <= upd_nx;
      prev_gray <= prev_nx;
      err_multi <= err_nx;
    end
  end
endmodule

// File: tb/tb_gray_ptr_rx.sv
// tb_gray_ptr_rx: directed checks of sync latency, decode, advance, wrap, priming and error flag
module tb_gray_ptr_rx;
  logic clk = 0;
  logic rst_n, err_clr, update, err_multi, primed;
  logic [7:0] gray_in, gray_sync, bin_out, advance;
  int errs = 0;
  int checks = 0;
  gray_ptr_rx #(.WIDTH(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .gray_in(gray_in), .err_clr(err_clr),
    .gray_sync(gray_sync), .bin_out(bin_out), .advance(advance),
    .update(update), .err_multi(err_multi), .primed(primed)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic all_zero(input string tag);
    chk({tag, "_bin"}, 32'(bin_out), 0);
    chk({tag, "_adv"}, 32'(advance), 0);
    chk({tag, "_upd"}, 32'(update), 0);
    chk({tag, "_err"}, 32'(err_multi), 0);
    chk({tag, "_primed"}, 32'(primed), 0);
    chk({tag, "_sync"}, 32'(gray_sync), 0);
  endtask
  function automatic logic [7:0] to_gray(input logic [7:0] b);
    return b ^ (b >> 1);
  endfunction
  initial begin
    rst_n = 0; gray_in = 8'h00; err_clr = 0;
    tick(); tick();
    all_zero("rst");
    rst_n = 1;
    tick(); chk("p1_primed", 32'(primed), 0);
    tick(); chk("p2_primed", 32'(primed), 0);
    tick();
    chk("p3_primed", 32'(primed), 1);
    chk("p3_bin", 32'(bin_out), 0);
    chk("p3_upd", 32'(update), 0);
    for (int b = 1; b < 256; b++) begin
      gray_in = to_gray(8'(b));
      tick(); tick();
      chk("cnt_hold_upd", 32'(update), 0);
      chk("cnt_hold_bin", 32'(bin_out), 32'(b - 1));
      tick();
      chk("cnt_bin", 32'(bin_out), 32'(b));
      chk("cnt_upd", 32'(update), 1);
      chk("cnt_adv", 32'(advance), 1);
    end
    chk("cnt_err", 32'(err_multi), 0);
    gray_in = 8'h00;
    tick(); tick(); tick();
    chk("wrap_bin", 32'(bin_out), 0);
    chk("wrap_upd", 32'(update), 1);
    chk("wrap_adv", 32'(advance), 1);
    chk("wrap_err", 32'(err_multi), 0);
    tick();
    chk("wrap_idle_upd", 32'(update), 0);
    chk("wrap_idle_adv", 32'(advance), 0);
    gray_in = 8'h03;
    tick(); tick();
    chk("viol_pre_err", 32'(err_multi), 0);
    tick();
    chk("viol_bin", 32'(bin_out), 8'h02);
    chk("viol_adv", 32'(advance), 8'h02);
    chk("viol_err", 32'(err_multi), 1);
    tick(); tick();
    chk("viol_sticky", 32'(err_multi), 1);
    chk("viol_idle_upd", 32'(update), 0);
    err_clr = 1; tick(); err_clr = 0;
    chk("clr_err", 32'(err_multi), 0);
    gray_in = 8'h00;
    tick(); tick(); tick();
    chk("back_bin", 32'(bin_out), 0);
    chk("back_adv", 32'(advance), 8'hFE);
    chk("back_err", 32'(err_multi), 1);
    gray_in = 8'h03;
    tick(); tick();
    err_clr = 1; tick(); err_clr = 0;
    chk("simul_err", 32'(err_multi), 1);
    chk("simul_upd", 32'(update), 1);
    chk("simul_bin", 32'(bin_out), 8'h02);
    err_clr = 1; tick(); err_clr = 0;
    chk("simul_clr", 32'(err_multi), 0);
    gray_in = to_gray(8'h55);
    tick(); tick(); tick();
    chk("mid_bin", 32'(bin_out), 8'h55);
    chk("mid_err", 32'(err_multi), 1);
    rst_n = 0; tick(); rst_n = 1;
    all_zero("mid_rst");
    tick(); chk("mid_p1_primed", 32'(primed), 0);
    tick();
    chk("mid_p2_primed", 32'(primed), 0);
    chk("mid_p2_sync", 32'(gray_sync), 8'h7F);
    tick();
    chk("mid_p3_primed", 32'(primed), 1);
    chk("mid_p3_bin", 32'(bin_out), 8'h55);
    chk("mid_p3_upd", 32'(update), 0);
    rst_n = 0; gray_in = 8'hC0;
    tick(); tick();
    rst_n = 1;
    tick(); tick();
    chk("prime_p2_primed", 32'(primed), 0);
    tick();
    chk("prime_bin", 32'(bin_out), 8'h80);
    chk("prime_primed", 32'(primed), 1);
    chk("prime_upd", 32'(update), 0);
    chk("prime_err", 32'(err_multi), 0);
    tick();
    chk("prime_idle_upd", 32'(update), 0);
    chk("prime_idle_bin", 32'(bin_out), 8'h80);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
